// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-outstanding memory between instruction fetch (IF)
// and data memory (DM) ports. DM has priority, bounded by a starvation counter for IF.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_stall,
  // data memory port
  input  logic        dm_ce,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  // shared memory
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  localparam logic [2:0] WAIT_LOAD = 3'(LATENCY - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e      state_q,     state_d;
  owner_e      owner_q,     owner_d;
  logic        op_we_q,     op_we_d;
  logic        mem_ce_q,    mem_ce_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  wait_cnt_q,  wait_cnt_d;
  logic [3:0]  starve_q,    starve_d;
  logic [31:0] if_data_q,   if_data_d;
  logic [31:0] dm_rdata_q,  dm_rdata_d;
  logic        grant_dm;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    owner_d     = owner_q;
    op_we_d     = op_we_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;
    grant_dm    = dm_ce && !(if_en && (starve_q == STARVE_LIM));

    case (state_q)
      S_IDLE: begin
        if (!if_en) starve_d = 4'd0;
        if (if_en || dm_ce) begin
          state_d  = S_ISSUE;
          mem_ce_d = 1'b1;
          if (grant_dm) begin
            owner_d     = OWN_DM;
            op_we_d     = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (if_en && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          end else begin
            owner_d     = OWN_IF;
            op_we_d     = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = 32'd0;
            starve_d    = 4'd0;
          end
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = WAIT_LOAD;
      end
      S_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = S_RESP;
          // Writes never touch the read-data registers, even for a dropped request.
          if (owner_q == OWN_IF)  if_data_d  = mem_rdata;
          else if (!op_we_q)      dm_rdata_d = mem_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers, data included, are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      op_we_q     <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      wait_cnt_q  <= 3'd0;
      starve_q    <= 4'd0;
      if_data_q   <= 32'd0;
      dm_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_we_q     <= op_we_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_data   = if_data_q;
  assign dm_rdata  = dm_rdata_q;

  // Stall follows the port's own request, so a dropped request never stalls anyone.
  assign if_stall = if_en && !((state_q == S_RESP) && (owner_q == OWN_IF));
  assign dm_stall = dm_ce && !((state_q == S_RESP) && (owner_q == OWN_DM));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a (LATENCY=1, STARVE_MAX=4) and instance b (LATENCY=3).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a
  logic        a_if_en = 0, a_dm_ce = 0, a_dm_we = 0;
  logic [31:0] a_if_addr = 0, a_dm_addr = 0, a_dm_wdata = 0, a_mem_rdata = 0;
  logic [31:0] a_if_data, a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic        a_if_stall, a_dm_stall, a_mem_ce, a_mem_we;
  // instance b
  logic        b_if_en = 0, b_dm_ce = 0, b_dm_we = 0;
  logic [31:0] b_if_addr = 0, b_dm_addr = 0, b_dm_wdata = 0, b_mem_rdata = 0;
  logic [31:0] b_if_data, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_stall, b_dm_stall, b_mem_ce, b_mem_we;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.LATENCY(1), .STARVE_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_en(a_if_en), .if_addr(a_if_addr), .if_data(a_if_data), .if_stall(a_if_stall),
    .dm_ce(a_dm_ce), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_stall(a_dm_stall),
    .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.LATENCY(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_en(b_if_en), .if_addr(b_if_addr), .if_data(b_if_data), .if_stall(b_if_stall),
    .dm_ce(b_dm_ce), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_stall(b_dm_stall),
    .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] grant_exp [6];

  initial begin
    grant_exp[0] = 32'h400; grant_exp[1] = 32'h400; grant_exp[2] = 32'h400;
    grant_exp[3] = 32'h400; grant_exp[4] = 32'h500; grant_exp[5] = 32'h400;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_ce",   {31'd0, a_mem_ce},   32'd0);
    check("rst_mem_addr", a_mem_addr,          32'd0);
    check("rst_if_data",  a_if_data,           32'd0);
    check("rst_dm_rdata", a_dm_rdata,          32'd0);
    check("rst_b_mem_ce", {31'd0, b_mem_ce},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single fetch, LATENCY=1: ISSUE cycle 1, unstall cycle 3
    a_if_en = 1; a_if_addr = 32'h100; #1;
    check("if_c0_stall", {31'd0, a_if_stall}, 32'd1);
    check("if_c0_ce",    {31'd0, a_mem_ce},   32'd0);
    tick();
    check("if_c1_ce",    {31'd0, a_mem_ce},   32'd1);
    check("if_c1_addr",  a_mem_addr,          32'h100);
    check("if_c1_we",    {31'd0, a_mem_we},   32'd0);
    a_mem_rdata = 32'h2402000A;
    tick();
    check("if_c2_ce",    {31'd0, a_mem_ce},   32'd0);
    check("if_c2_stall", {31'd0, a_if_stall}, 32'd1);
    tick();
    check("if_c3_stall", {31'd0, a_if_stall}, 32'd0);
    check("if_c3_data",  a_if_data,           32'h2402000A);
    a_if_en = 0;
    tick();

    // DM read so dm_rdata holds a known value
    a_dm_ce = 1; a_dm_we = 0; a_dm_addr = 32'h208;
    tick();
    check("dmr_addr", a_mem_addr, 32'h208);
    a_mem_rdata = 32'h11223344;
    tick();
    check("dmr_wait_stall", {31'd0, a_dm_stall}, 32'd1);
    tick();
    check("dmr_resp_stall", {31'd0, a_dm_stall}, 32'd0);
    check("dmr_data", a_dm_rdata, 32'h11223344);
    a_dm_ce = 0;
    tick();

    // simultaneous requests: DM write first, then IF
    a_if_en = 1; a_if_addr = 32'h104;
    a_dm_ce = 1; a_dm_we = 1; a_dm_addr = 32'h200; a_dm_wdata = 32'hDEADBEEF;
    tick();
    check("both_issue_we",    {31'd0, a_mem_we}, 32'd1);
    check("both_issue_addr",  a_mem_addr,        32'h200);
    check("both_issue_wdata", a_mem_wdata,       32'hDEADBEEF);
    a_mem_rdata = 32'h55555555;
    tick();
    check("both_wait_we", {31'd0, a_mem_we}, 32'd0);
    tick();
    check("both_dm_resp",  {31'd0, a_dm_stall}, 32'd0);
    check("both_if_held",  {31'd0, a_if_stall}, 32'd1);
    check("wr_keeps_rdata", a_dm_rdata,         32'h11223344);
    a_dm_ce = 0; a_dm_we = 0;
    tick();
    tick();
    check("if2_addr",  a_mem_addr,          32'h104);
    check("if2_we",    {31'd0, a_mem_we},   32'd0);
    check("if2_wdata", a_mem_wdata,         32'd0);
    a_mem_rdata = 32'h0000CAFE;
    tick();
    tick();
    check("if2_stall", {31'd0, a_if_stall}, 32'd0);
    check("if2_data",  a_if_data,           32'h0000CAFE);

    // starvation: both held continuously
    a_dm_ce = 1; a_dm_we = 0; a_dm_addr = 32'h400; a_if_addr = 32'h500;
    for (int g = 0; g < 6; g++) begin
      int w;
      w = 0;
      do begin
        tick();
        w++;
      end while (!a_mem_ce && w < 8);
      check($sformatf("starve_ce%0d", g),    {31'd0, a_mem_ce}, 32'd1);
      check($sformatf("starve_grant%0d", g), a_mem_addr,        grant_exp[g]);
    end

    // DM drops its request during ISSUE: data still captured, no stalls
    a_dm_ce = 0; a_if_en = 0; a_mem_rdata = 32'h77778888;
    tick();
    check("drop_dm_stall", {31'd0, a_dm_stall}, 32'd0);
    check("drop_if_stall", {31'd0, a_if_stall}, 32'd0);
    tick();
    tick();
    check("drop_data",    a_dm_rdata,        32'h77778888);
    check("drop_idle_ce", {31'd0, a_mem_ce}, 32'd0);

    // reset during WAIT
    a_if_en = 1; a_if_addr = 32'h600;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_addr",   a_mem_addr,          32'd0);
    check("mrst_ifdata", a_if_data,           32'd0);
    check("mrst_dmdata", a_dm_rdata,          32'd0);
    check("mrst_stall",  {31'd0, a_if_stall}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("mrst_reissue_ce",   {31'd0, a_mem_ce},   32'd1);
    check("mrst_reissue_addr", a_mem_addr,          32'h600);
    check("mrst_no_resp",      {31'd0, a_if_stall}, 32'd1);
    a_mem_rdata = 32'h600D600D;
    tick();
    tick();
    check("mrst_stall_done", {31'd0, a_if_stall}, 32'd0);
    check("mrst_data",       a_if_data,           32'h600D600D);
    a_if_en = 0;

    // LATENCY=3 read on instance b; mem_rdata changes every cycle to pin the capture cycle
    tick();
    b_dm_ce = 1; b_dm_we = 0; b_dm_addr = 32'h300;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      b_mem_rdata = 32'hB0000000 + 32'(k);
      #1;
      check($sformatf("lat3_stall_c%0d", k), {31'd0, b_dm_stall}, (k < 5) ? 32'd1 : 32'd0);
      if (k == 1) begin
        check("lat3_ce",   {31'd0, b_mem_ce}, 32'd1);
        check("lat3_addr", b_mem_addr,        32'h300);
      end
    end
    check("lat3_data", b_dm_rdata, 32'hB0000004);
    b_dm_ce = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
